wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter placed between the execute-stage result producers and the integer register file write port. Merges a single-cycle ALU result stream and a buffered multi-cycle MDU (mult/div) result stream into one registered write per cycle (reg_write/rd/write_data). Provides a fairness stall so the MDU queue cannot starve, and a pending-destination mask the issue stage uses for hazard checks.

## Interface
- DEPTH, 4, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive ALU-won cycles with FIFO non-empty before the FIFO is forced a slot

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; **asynchronous, active-low**
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU result not taken this cycle; producer holds alu_valid/alu_rd/alu_data stable
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept (= not full)
- mdu_rd  in  5  MDU destination register
- mdu_data  in  32  MDU result
- reg_write  out  1  register file write enable (registered)
- rd  out  5  register file write address (registered)
- write_data  out  32  register file write data (registered)
- pending  out  32  bit i set iff some valid FIFO entry targets register i; bit 0 always 0

## Operation
- Push: mdu_valid && mdu_ready stores {mdu_rd, mdu_data} at tail. No push-through when full, even if a pop occurs in the same cycle.
- Per cycle, at most one winner:
  - alu_valid=1 and not forced: ALU wins; FIFO holds.
  - forced (starve count == STARVE_MAX, FIFO non-empty, alu_valid=1): FIFO head pops, alu_stall=1, counter clears.
  - alu_valid=0 and FIFO non-empty: FIFO head pops.
  - neither: no write.
- Starve counter (0..STARVE_MAX): increments when ALU wins with FIFO non-empty; clears on any pop or when the FIFO is empty.
- Winner registered into rd/write_data. reg_write=1 only if winner exists and winner rd != 0. An rd=0 entry is still consumed; rd/write_data still update.
- pending: combinational OR over valid entries of one-hot(rd); mask bit 0. Cleared in the cycle after the entry pops.
- No ordering check between streams; the issue stage uses pending to avoid same-rd WAW.
- FIFO pointers are DEPTH-wrapping with an explicit count (0..DEPTH); full when count==DEPTH.

## Timing
- Reset (async assert, sync-released use): reg_write=0, rd=0, write_data=0, FIFO empty, count=0, starve=0, pending=0, alu_stall=0, mdu_ready=1.
- ALU latency: alu_valid at edge N -> reg_write/rd/write_data valid after edge N+1 (1 cycle).
- MDU minimum latency: push at edge N, earliest pop at edge N+1, write visible after edge N+1 (1 cycle after push edge), when ALU idle.
- alu_stall is combinational from alu_valid, FIFO state and counter; asserted only in forced cycles.
- Reset mid-operation: FIFO contents discarded, no write issued, pending cleared immediately.
- Simultaneous push and pop while not full: count unchanged, both succeed.

## Structure
- Shared pipeline package: WB_REG_W=5, WB_DATA_W=32, and a packed wb_entry_t {rd, data}.
- One sub-module: wb_fifo (sync FIFO, count-based full/empty, exposes storage valid bits for pending generation). Arbitration, starve counter and output registers stay in wb_arbiter.

## Test plan
- Reset: hold rst_n=0 mid-stream -> all outputs zero, mdu_ready=1, pending=0.
- ALU only: alu_valid, rd=5, data=0x1234 -> next cycle reg_write=1, rd=5, write_data=0x1234; alu_rd=0 -> reg_write=0.
- MDU only: push rd=7/0xDEAD, rd=9/0xBEEF -> writes in order on consecutive cycles; pending=0x280 then 0x200 then 0.
- Full FIFO: push 4 with ALU busy -> mdu_ready=0; 5th offer held until a pop; no data lost or duplicated.
- Starvation: FIFO holds 1 entry, alu_valid held high -> ALU wins 4 cycles, 5th cycle alu_stall=1 and MDU entry written; the held ALU result is written the following cycle.
- Simultaneous push/pop at count=2, ALU idle -> count stays 2, order preserved.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared pipeline definitions for the writeback path.
//   WB_REG_W   : register index width
//   WB_DATA_W  : register data width
//   wb_entry_t : one buffered writeback {rd, data}
package wb_arbiter_pkg;

    localparam int unsigned WB_REG_W  = 5;
    localparam int unsigned WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_REG_W-1:0]  rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result stream, MDU result stream,
// register-file write port and the pending-destination mask.
//   master : result producers / register file side
//   slave  : the arbiter
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                 alu_valid;
    logic [WB_REG_W-1:0]  alu_rd;
    logic [WB_DATA_W-1:0] alu_data;
    logic                 alu_stall;

    logic                 mdu_valid;
    logic                 mdu_ready;
    logic [WB_REG_W-1:0]  mdu_rd;
    logic [WB_DATA_W-1:0] mdu_data;

    logic                 reg_write;
    logic [WB_REG_W-1:0]  rd;
    logic [WB_DATA_W-1:0] write_data;
    logic [31:0]          pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_stall,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready,
        input  reg_write, rd, write_data, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_stall,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready,
        output reg_write, rd, write_data, pending
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries with count-based
// full/empty. Exposes storage and per-slot valid bits so the arbiter
// can build the pending-destination mask.
//   clk, rst_n   : clock, async active-low reset
//   push, wr     : store wr at tail (ignored when full)
//   pop          : drop head (ignored when empty)
//   head         : entry at head
//   full, empty  : occupancy flags
//   mem, valid   : raw storage and slot-valid bits
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_entry_t              wr,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output wb_entry_t [DEPTH-1:0]  mem,
    output logic [DEPTH-1:0]       valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Full blocks the push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr]   <= wr;
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the single-cycle ALU result stream and the buffered
// MDU result stream into one registered register-file write per cycle.
// A starve counter forces the MDU queue a slot after STARVE_MAX
// consecutive ALU wins while the queue is non-empty.
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_arbiter_if slave (ALU in, MDU in, write port, pending)
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    wb_entry_t              head;
    wb_entry_t [DEPTH-1:0]  mem;
    logic [DEPTH-1:0]       valid;
    logic                   full;
    logic                   empty;
    logic                   forced;
    logic                   alu_win;
    logic                   pop;
    logic [STARVE_W-1:0]    starve;
    logic [31:0]            pending_c;

    logic                   reg_write_q;
    logic [WB_REG_W-1:0]    rd_q;
    logic [WB_DATA_W-1:0]   write_data_q;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.mdu_valid),
        .wr    ({bus.mdu_rd, bus.mdu_data}),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .mem   (mem),
        .valid (valid)
    );

    assign forced  = bus.alu_valid && !empty && (starve == STARVE_LIM);
    assign alu_win = bus.alu_valid && !forced;
    assign pop     = !empty && (forced || !bus.alu_valid);

    assign bus.alu_stall  = forced;
    assign bus.mdu_ready  = !full;
    assign bus.reg_write  = reg_write_q;
    assign bus.rd         = rd_q;
    assign bus.write_data = write_data_q;
    assign bus.pending    = pending_c;

    always_comb begin
        pending_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i]) pending_c[mem[i].rd] = 1'b1;
        end
        pending_c[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (pop || empty) begin
            starve <= '0;
        end else if (alu_win && starve != STARVE_LIM) begin
            starve <= starve + STARVE_W'(1);
        end
    end

    // rd/write_data hold when there is no winner; an rd=0 winner still
    // updates them but suppresses reg_write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
        end else if (alu_win) begin
            reg_write_q  <= (bus.alu_rd != '0);
            rd_q         <= bus.alu_rd;
            write_data_q <= bus.alu_data;
        end else if (pop) begin
            reg_write_q  <= (head.rd != '0);
            rd_q         <= head.rd;
            write_data_q <= head.data;
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

endmodule
